// File: rtl/mxint8_negate_seq.sv
// MXINT8 block negation, LANES elements per cycle over NBEATS cycles.
// Ready/valid handshake on both sides; one block is in flight at a time.
module mxint8_negate_seq #(
  parameter int unsigned BLOCK_SIZE = 32,
  parameter int unsigned LANES      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_scale,
  input  logic [BLOCK_SIZE*8-1:0]       in_elements,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_scale,
  output logic [BLOCK_SIZE*8-1:0]       out_elements,
  output logic [$clog2(BLOCK_SIZE):0]   out_zero_num,
  output logic                          out_is_nan,
  output logic                          out_sat,
  output logic                          busy
);

  localparam int unsigned NBEATS    = BLOCK_SIZE / LANES;
  localparam int unsigned ZW        = $clog2(BLOCK_SIZE) + 1;
  localparam int unsigned BW        = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned IW        = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [7:0]  NAN_SCALE = 8'hFF;
  localparam logic [7:0]  MIN_VAL   = 8'h80;
  localparam logic [7:0]  MAX_VAL   = 8'h7F;

  typedef enum logic [1:0] {
    IDLE,
    PROC,
    DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [BW-1:0]              beat_q, beat_d;
  logic [7:0]                 scale_q, scale_d;
  logic [BLOCK_SIZE-1:0][7:0] elem_q, elem_d;
  logic [ZW-1:0]              zero_q, zero_d;
  logic                       sat_q, sat_d;

  logic                       is_nan;
  logic [IW-1:0]              idx;
  logic [7:0]                 x;
  logic [7:0]                 r;
  logic [ZW-1:0]              beat_zeros;
  logic                       beat_sat;

  assign is_nan       = (scale_q == NAN_SCALE);
  assign in_ready     = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_scale    = scale_q;
  assign out_elements = elem_q;
  assign out_zero_num = zero_q;
  assign out_is_nan   = is_nan;
  assign out_sat      = sat_q;

  // Next-state logic: accept in IDLE, negate one beat per PROC cycle in place, hold in DONE.
  // The latched input buffer doubles as the result buffer; each beat overwrites its own lanes.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    scale_d    = scale_q;
    elem_d     = elem_q;
    zero_d     = zero_q;
    sat_d      = sat_q;
    beat_zeros = '0;
    beat_sat   = 1'b0;
    idx        = '0;
    x          = '0;
    r          = '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          scale_d = in_scale;
          elem_d  = in_elements;
          beat_d  = '0;
          zero_d  = '0;
          sat_d   = 1'b0;
          state_d = PROC;
        end
      end
      PROC: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          idx = IW'(32'(beat_q) * LANES + l);
          x   = elem_q[idx];
          if (is_nan) begin
            r = '0;
          end else if (x == MIN_VAL) begin
            r        = MAX_VAL;
            beat_sat = 1'b1;
          end else begin
            r = ~x + 8'd1;
          end
          elem_d[idx] = r;
          if (r == '0) begin
            beat_zeros = beat_zeros + ZW'(1);
          end
        end
        zero_d = zero_q + beat_zeros;
        sat_d  = sat_q | beat_sat;
        beat_d = beat_q + BW'(1);
        if (beat_q == BW'(NBEATS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; asynchronous reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      scale_q <= '0;
      elem_q  <= '0;
      zero_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      scale_q <= scale_d;
      elem_q  <= elem_d;
      zero_q  <= zero_d;
      sat_q   <= sat_d;
    end
  end

endmodule
